pll_relock_supervisor: RTL

//  Supervises the PLL soft-logic output resync sequencer in the CCC: drives its RESET_N and watches PLL lock.

---
 rtl/pll_relock_supervisor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_relock_supervisor.sv
// PLL relock supervisor: drives the resync sequencer reset, filters PLL lock, retries and faults.
// Optional IRQ output is built in when PLL_RELOCK_IRQ_EN is defined.
module pll_relock_supervisor #(
  parameter int SEQ_RESET_CYCLES = 16,
  parameter int FILTER_LEN       = 8,
  parameter int LOCK_TIMEOUT     = 1000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       FREF,
  input  logic       RESET_N,
  input  logic       PLL_LOCK,
  input  logic       RELOCK_REQ,
  output logic       SEQ_RESET_N,
  output logic       CLK_VALID,
  output logic       FAULT,
  output logic [7:0] RELOCK_COUNT,
`ifdef PLL_RELOCK_IRQ_EN
  output logic       IRQ,
`endif
  output logic [2:0] STATE_DBG
);

  localparam int RUN_W = $clog2(FILTER_LEN + 1);
  localparam int RET_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [15:0]      SEQ_LAST  = 16'(SEQ_RESET_CYCLES - 1);
  localparam logic [15:0]      TO_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [RUN_W-1:0] FILT_LAST = RUN_W'(FILTER_LEN - 1);
  localparam logic [RET_W-1:0] RET_MAX   = RET_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_SEQ_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_LOSS_FILT = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RET_W-1:0] retry_q, retry_d;
  logic             seq_d, valid_d, fault_d;
  logic [7:0]       count_d, count_inc;
  logic             relock_go;
  logic             sync1, lock_s;
`ifdef PLL_RELOCK_IRQ_EN
  logic             irq_d;
`endif

  assign STATE_DBG = state_q;

  always_ff @(posedge FREF or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= PLL_LOCK;
      lock_s <= sync1;
    end
  end

  assign count_inc = (RELOCK_COUNT == 8'hFF) ? 8'hFF : RELOCK_COUNT + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    retry_d   = retry_q;
    seq_d     = SEQ_RESET_N;
    valid_d   = CLK_VALID;
    fault_d   = FAULT;
    count_d   = RELOCK_COUNT;
    relock_go = 1'b0;
`ifdef PLL_RELOCK_IRQ_EN
    irq_d     = 1'b0;
`endif
    case (state_q)
      ST_SEQ_RST: begin
        seq_d   = 1'b0;
        valid_d = 1'b0;
        if (cnt_q == SEQ_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = 16'd0;
          run_d   = '0;
          seq_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock qualification is checked first so it wins over a coincident timeout.
        if (lock_s && run_q == FILT_LAST) begin
          state_d = ST_LOCKED;
          valid_d = 1'b1;
          retry_d = '0;
          run_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          cnt_d = 16'd0;
          run_d = '0;
          seq_d = 1'b0;
          if (retry_q < RET_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEQ_RST;
          end else begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
`ifdef PLL_RELOCK_IRQ_EN
            irq_d   = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          run_d = lock_s ? run_q + 1'b1 : '0;
        end
      end
      ST_LOCKED: begin
        if (RELOCK_REQ) begin
          relock_go = 1'b1;
        end else if (!lock_s) begin
          if (FILTER_LEN == 1) begin
            relock_go = 1'b1;
`ifdef PLL_RELOCK_IRQ_EN
            irq_d     = 1'b1;
`endif
          end else begin
            state_d = ST_LOSS_FILT;
            run_d   = RUN_W'(1);
          end
        end
      end
      ST_LOSS_FILT: begin
        // A request coinciding with loss qualification is a single relock.
        if (RELOCK_REQ) begin
          relock_go = 1'b1;
        end else if (lock_s) begin
          state_d = ST_LOCKED;
          run_d   = '0;
        end else if (run_q == FILT_LAST) begin
          relock_go = 1'b1;
`ifdef PLL_RELOCK_IRQ_EN
          irq_d     = 1'b1;
`endif
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      ST_FAULT: begin
        seq_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
        if (RELOCK_REQ) begin
          fault_d = 1'b0;
          retry_d = '0;
          cnt_d   = 16'd0;
          run_d   = '0;
          state_d = ST_SEQ_RST;
        end
      end
      default: begin
        state_d = ST_SEQ_RST;
        cnt_d   = 16'd0;
        run_d   = '0;
        seq_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    if (relock_go) begin
      state_d = ST_SEQ_RST;
      cnt_d   = 16'd0;
      run_d   = '0;
      seq_d   = 1'b0;
      valid_d = 1'b0;
      count_d = count_inc;
    end
  end

  always_ff @(posedge FREF or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_SEQ_RST;
      cnt_q        <= 16'd0;
      run_q        <= '0;
      retry_q      <= '0;
      SEQ_RESET_N  <= 1'b0;
      CLK_VALID    <= 1'b0;
      FAULT        <= 1'b0;
      RELOCK_COUNT <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      retry_q      <= retry_d;
      SEQ_RESET_N  <= seq_d;
      CLK_VALID    <= valid_d;
      FAULT        <= fault_d;
      RELOCK_COUNT <= count_d;
    end
  end

`ifdef PLL_RELOCK_IRQ_EN
  always_ff @(posedge FREF or negedge RESET_N) begin
    if (!RESET_N) IRQ <= 1'b0;
    else          IRQ <= irq_d;
  end
`endif

endmodule
